// File: rtl/hex_loader_pkg.sv
// Shared types and constants for the serial hex program loader.
package hex_loader_pkg;

    // Load-controller states.
    typedef enum logic [2:0] {
        IDLE,
        WAIT_FIRST,
        LOADING,
        DONE,
        FAIL
    } state_t;

    // Controller-side error codes (parser codes pass through unchanged).
    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_OVERRUN = 3'd1;
    localparam logic [2:0] ERR_RANGE   = 3'd2;
    localparam logic [2:0] ERR_TRUNC   = 3'd3;

    // A load is in progress in these two states.
    function automatic logic is_busy(input state_t s);
        return (s == WAIT_FIRST) || (s == LOADING);
    endfunction

endpackage

// File: rtl/hex_loader_ctrl_pacer.sv
// Byte pacer: forwards UART bytes to the hex parser with at least one idle
// cycle between strobes, buffering one early byte in a skid register.
module hex_byte_pacer (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_flush,
    input  logic       i_accept,
    input  logic [7:0] i_data,
    output logic       o_hex_en,
    output logic [7:0] o_hex_data,
    output logic       o_overrun
);

    logic       skid_full;
    logic [7:0] skid_data;

    // A byte arriving while the skid register is still occupied has nowhere to go.
    assign o_overrun = i_accept && skid_full;

    // Strobe/skid sequencing: one strobe at most every other cycle, skid drains first.
    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the values from before this edge, independent of statement order.
        if (i_rst || i_flush) begin
            o_hex_en   <= 1'b0;
            o_hex_data <= 8'h00;
            skid_full  <= 1'b0;
            skid_data  <= 8'h00;
        end else if (o_hex_en) begin
            // Strobe is being issued now; the next cycle must stay idle.
            o_hex_en <= 1'b0;
            if (i_accept) begin
                skid_full <= 1'b1;
                skid_data <= i_data;
            end
        end else if (skid_full) begin
            // A byte arriving here is an overrun; the controller flushes us anyway.
            o_hex_en   <= 1'b1;
            o_hex_data <= skid_data;
            skid_full  <= 1'b0;
        end else if (i_accept) begin
            o_hex_en   <= 1'b1;
            o_hex_data <= i_data;
        end
    end

endmodule

// File: rtl/hex_loader_ctrl.sv
// Serial program-load controller: paces UART bytes into the intel_hex parser,
// turns parser output into program-RAM writes, holds the CPU in reset during
// a load and reports success or the cause of failure.
module hex_loader_ctrl
    import hex_loader_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int MEM_DEPTH      = 4096,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    output logic              o_hex_en,
    output logic [7:0]        o_hex_data,
    input  logic [ADDR_W-1:0] i_hex_addr,
    input  logic [7:0]        i_hex_data,
    input  logic              i_hex_idle,
    input  logic              i_hex_data_valid,
    input  logic [2:0]        i_hex_error,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_data,
    output logic              o_cpu_rst,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_fail_src,
    output logic [2:0]        o_error_code,
    output logic [15:0]       o_byte_count
);

    localparam int              TO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);

    state_t          state_q;
    state_t          state_d;
    logic [TO_W-1:0] to_cnt_q;
    logic            busy;
    logic            start_go;
    logic            rx_accept;
    logic            overrun;
    logic            pacer_flush;
    logic            parser_err;
    logic            in_range;
    logic            range_err;
    logic            write_ok;
    logic            timeout_hit;
    logic            set_fail;
    logic            fail_src_d;
    logic [2:0]      fail_code_d;
    logic            fail_src_q;
    logic [2:0]      err_q;
    logic [15:0]     byte_cnt_q;

    assign busy        = is_busy(state_q);
    assign start_go    = i_start && !busy;
    assign rx_accept   = i_rx_valid && busy;
    assign parser_err  = busy && (i_hex_error != ERR_NONE);
    assign in_range    = {1'b0, i_hex_addr} < DEPTH_LIM;
    assign range_err   = busy && i_hex_data_valid && !in_range;
    assign write_ok    = busy && i_hex_data_valid && in_range && !parser_err;
    // The terminal silent cycle; an rx byte in the same cycle restarts the count instead.
    assign timeout_hit = (state_q == LOADING) && !i_rx_valid && (to_cnt_q == TO_LAST);
    // Leaving the busy states drops any byte still queued for the parser.
    assign pacer_flush = !is_busy(state_d);

    hex_byte_pacer u_pacer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_flush    (pacer_flush),
        .i_accept   (rx_accept),
        .i_data     (i_rx_data),
        .o_hex_en   (o_hex_en),
        .o_hex_data (o_hex_data),
        .o_overrun  (overrun)
    );

    // Next-state and failure classification; parser errors outrank controller errors.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves one unassigned and infers a latch.
        state_d     = state_q;
        set_fail    = 1'b0;
        fail_src_d  = 1'b0;
        fail_code_d = ERR_NONE;
        case (state_q)
            IDLE, DONE, FAIL: begin
                if (i_start) state_d = WAIT_FIRST;
            end
            WAIT_FIRST, LOADING: begin
                if (state_q == WAIT_FIRST && i_rx_valid) state_d = LOADING;
                if (parser_err) begin
                    set_fail    = 1'b1;
                    fail_src_d  = 1'b0;
                    fail_code_d = i_hex_error;
                end else if (overrun) begin
                    set_fail    = 1'b1;
                    fail_src_d  = 1'b1;
                    fail_code_d = ERR_OVERRUN;
                end else if (range_err) begin
                    set_fail    = 1'b1;
                    fail_src_d  = 1'b1;
                    fail_code_d = ERR_RANGE;
                end else if (timeout_hit) begin
                    if (i_hex_idle) begin
                        state_d = DONE;
                    end else begin
                        set_fail    = 1'b1;
                        fail_src_d  = 1'b1;
                        fail_code_d = ERR_TRUNC;
                    end
                end
                if (set_fail) state_d = FAIL;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Inter-byte silence counter; only runs in LOADING and restarts on every rx byte.
    always_ff @(posedge i_clk) begin
        if (i_rst || state_q != LOADING || i_rx_valid) begin
            to_cnt_q <= '0;
        end else if (to_cnt_q != TO_LAST) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    // Registered RAM write port.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_mem_we   <= 1'b0;
            o_mem_addr <= '0;
            o_mem_data <= 8'h00;
        end else begin
            o_mem_we <= write_ok;
            if (write_ok) begin
                o_mem_addr <= i_hex_addr;
                o_mem_data <= i_hex_data;
            end
        end
    end

    // Load status: error latch held until the next start, saturating write count.
    always_ff @(posedge i_clk) begin
        if (i_rst || start_go) begin
            fail_src_q <= 1'b0;
            err_q      <= ERR_NONE;
            byte_cnt_q <= 16'h0000;
        end else begin
            if (set_fail) begin
                fail_src_q <= fail_src_d;
                err_q      <= fail_code_d;
            end
            if (write_ok && byte_cnt_q != 16'hFFFF) byte_cnt_q <= byte_cnt_q + 16'd1;
        end
    end

    assign o_busy       = busy;
    assign o_done       = (state_q == DONE);
    assign o_cpu_rst    = busy || (state_q == FAIL);
    assign o_fail_src   = fail_src_q;
    assign o_error_code = err_q;
    assign o_byte_count = byte_cnt_q;

endmodule

// File: doc/hex_loader_ctrl.md
Name: hex_loader_ctrl

Overview:
- Sequences the intel_hex parser for serial program loading: accepts raw bytes from a UART receiver, paces them into the parser, and turns parser output into program-RAM writes.
- Holds the CPU in reset while a load is in progress.
- Decides end-of-load (inter-byte silence timeout) and reports success, parser errors or controller errors.
- Sits between uart_rx, intel_hex, the program BRAM write port and the CPU reset input.

Parameters:
- ADDR_W, 16, width of the parser address and the memory address.
- MEM_DEPTH, 4096, number of writable bytes; valid addresses are 0..MEM_DEPTH-1.
- TIMEOUT_CYCLES, 1000000, silent cycles after the last rx byte that end a load.

Ports:
- i_clk  in  1  system clock; single clock domain
- i_rst  in  1  synchronous reset, active-high
- i_start  in  1  begin a load; sampled in IDLE, DONE and FAIL only
- i_rx_valid  in  1  one-cycle strobe: new byte from UART
- i_rx_data  in  8  UART byte
- o_hex_en  out  1  strobe to intel_hex i_en
- o_hex_data  out  8  byte to intel_hex i_data
- i_hex_addr  in  ADDR_W  from intel_hex o_addr
- i_hex_data  in  8  from intel_hex o_data
- i_hex_idle  in  1  from intel_hex o_idle
- i_hex_data_valid  in  1  from intel_hex o_data_valid
- i_hex_error  in  3  from intel_hex o_error_code; 0 = no error
- o_mem_we  out  1  RAM write strobe
- o_mem_addr  out  ADDR_W  RAM write address
- o_mem_data  out  8  RAM write data
- o_cpu_rst  out  1  CPU reset hold
- o_busy  out  1  load in progress (WAIT_FIRST or LOADING)
- o_done  out  1  last load succeeded
- o_fail_src  out  1  0 = parser error, 1 = controller error
- o_error_code  out  3  latched error code; 0 when no failure
- o_byte_count  out  16  RAM bytes written this load, saturating at 16'hFFFF

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0: o_hex_en, o_hex_data, o_mem_we, o_mem_addr, o_mem_data, o_cpu_rst, o_busy, o_done, o_fail_src, o_error_code, o_byte_count.
  - The skid register and timeout counter clear.
  - Reset mid-load aborts immediately with no further writes; o_cpu_rst drops the cycle after reset.
- States are IDLE, WAIT_FIRST, LOADING, DONE, FAIL.
- IDLE/DONE/FAIL + i_start -> WAIT_FIRST:
  - o_cpu_rst=1; clear o_done, o_error_code, o_fail_src, o_byte_count and the timeout counter.
  - i_start in WAIT_FIRST or LOADING is ignored.
- WAIT_FIRST:
  - No timeout; waits indefinitely.
  - The first i_rx_valid is forwarded and moves the state to LOADING.
- Pacing: the parser needs at least one idle cycle between i_en strobes.
  - Accepted byte: o_hex_en=1 with o_hex_data on the next cycle (1-cycle latency).
  - o_hex_en is never high on two consecutive cycles.
  - A byte arriving while the previous strobe is still being issued goes into a 1-entry skid register and is forwarded on the next legal cycle.
  - If the skid register is full and another byte arrives -> FAIL, src=1, code 1 (overrun).
- Writes:
  - i_hex_data_valid -> o_mem_we=1 next cycle, with o_mem_addr=i_hex_addr and o_mem_data=i_hex_data registered.
  - o_byte_count increments on each write and saturates.
  - If i_hex_addr >= MEM_DEPTH: no write; FAIL, src=1, code 2.
- Parser error: i_hex_error != 0 in WAIT_FIRST or LOADING -> FAIL, src=0, code=i_hex_error latched.
  - Parser error has priority over controller errors raised in the same cycle.
  - A write whose data_valid coincides with the error is suppressed.
- Timeout:
  - The counter resets on every accepted rx byte and increments otherwise in LOADING.
  - On reaching TIMEOUT_CYCLES with i_hex_idle=1 -> DONE.
  - On reaching it with i_hex_idle=0 -> FAIL, src=1, code 3 (truncated record).
  - An rx byte arriving in the same cycle as the terminal count wins: the counter resets.
- DONE: o_cpu_rst=0, o_done=1, o_busy=0.
- FAIL:
  - o_cpu_rst stays 1 and o_done=0.
  - rx bytes are ignored.
  - The error is held until i_start or reset.
- In IDLE, DONE and FAIL: rx bytes are discarded and no o_hex_en is issued.
- o_busy=1 exactly in WAIT_FIRST and LOADING.

Decomposition:
- Package hex_loader_pkg holds:
  - state enum state_t {IDLE, WAIT_FIRST, LOADING, DONE, FAIL};
  - controller error constants ERR_OVERRUN=3'd1, ERR_RANGE=3'd2, ERR_TRUNC=3'd3.
- One sub-module, hex_byte_pacer, contains the skid register, enforces the one-idle-cycle spacing of o_hex_en and flags overrun.
- The FSM, timeout counter and write path stay in hex_loader_ctrl.

Test Plan:
- Clean load with TIMEOUT_CYCLES=16, MEM_DEPTH=4096: i_start, then a 2-record file (4 data bytes at 0x0100, EOF record) at 1 byte per 4 cycles -> 4 writes at 0x0100..0x0103 with the correct data, o_byte_count=4, DONE 16 cycles after the last byte, o_cpu_rst 1->0, o_done=1.
- Back-to-back rx on consecutive cycles (2 bytes) -> o_hex_en pulses exactly 2 cycles apart, no error. Three consecutive bytes -> FAIL, o_fail_src=1, o_error_code=1.
- Bad checksum in a record -> the parser's nonzero code is latched, o_fail_src=0, o_cpu_rst stays 1, no write after the error cycle.
- Data record at 0x1000 with MEM_DEPTH=4096 -> no o_mem_we, FAIL with code 2. Then i_start and a clean file -> DONE, counters cleared.
- Stop mid-record for more than 16 cycles -> FAIL with code 3. i_start during LOADING has no effect.
- Assert i_rst mid-LOADING -> next cycle IDLE, all outputs 0, no further o_mem_we, subsequent rx bytes produce no o_hex_en.
